// File: rtl/nx_stream_combiner_pkg.sv
// nx_stream_combiner_pkg: message and direction types used by the stream combiner.
// nx_direction_t encodes the four inbound directions in wrap order N,E,S,W.
package nx_stream_combiner_pkg;

  localparam int NX_MSG_W    = 12;
  localparam int NX_NUM_DIRS = 4;

  typedef logic [NX_MSG_W-1:0] nx_message_t;

  typedef enum logic [1:0] {
    NX_DIRX_NORTH = 2'd0,
    NX_DIRX_EAST  = 2'd1,
    NX_DIRX_SOUTH = 2'd2,
    NX_DIRX_WEST  = 2'd3
  } nx_direction_t;

  // Next direction in arbitration order; WEST wraps back to NORTH.
  function automatic nx_direction_t nx_dir_next(input nx_direction_t d);
    return nx_direction_t'(d + 2'd1);
  endfunction

endpackage

// File: rtl/nx_stream_combiner_if.sv
// nx_stream_combiner_if: one valid/ready message stream (message, source
// direction, valid, ready). The master drives data/dir/valid, the slave ready.
interface nx_stream_combiner_if;
  import nx_stream_combiner_pkg::*;

  nx_message_t   data;
  nx_direction_t dir;
  logic          valid;
  logic          ready;

  modport master (output data, output dir, output valid, input ready);
  modport slave  (input data, input dir, input valid, output ready);

endinterface

// File: rtl/nx_stream_combiner_fifo.sv
// nx_fifo: synchronous FIFO with registered storage and head-of-queue output.
// Pushes while full and pops while empty are ignored. DEPTH must be >= 2.
module nx_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + AW'(1);
    end
  endfunction

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == CW'(0));
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign rdata_o   = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset empties the queue immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

endmodule

// File: rtl/nx_stream_combiner.sv
// nx_stream_combiner: merges four inbound message streams (N/E/S/W) into one
// outbound stream tagged with the source direction, through an egress FIFO.
// Build option: define NX_COMBINER_RR_EN for round-robin arbitration;
// otherwise fixed priority NORTH > EAST > SOUTH > WEST.
// Inbound ready depends only on valids, grant state and FIFO full, never on
// comb_ready_i, so a full FIFO refuses input even in a cycle that pops.
module nx_stream_combiner
  import nx_stream_combiner_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          idle_o,
  input  nx_message_t   north_data_i,
  input  nx_message_t   east_data_i,
  input  nx_message_t   south_data_i,
  input  nx_message_t   west_data_i,
  input  logic          north_valid_i,
  input  logic          east_valid_i,
  input  logic          south_valid_i,
  input  logic          west_valid_i,
  output logic          north_ready_o,
  output logic          east_ready_o,
  output logic          south_ready_o,
  output logic          west_ready_o,
  output nx_message_t   comb_data_o,
  output nx_direction_t comb_dir_o,
  output logic          comb_valid_o,
  input  logic          comb_ready_i
);

  localparam int FIFO_W = $bits(nx_message_t) + $bits(nx_direction_t);

  logic [NX_NUM_DIRS-1:0] valid_s;
  logic [NX_NUM_DIRS-1:0] ready_s;
  nx_message_t            msg_s [NX_NUM_DIRS];
  logic                   grant_any_s;
  nx_direction_t          grant_dir_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [FIFO_W-1:0]      fifo_wdata_s;
  logic [FIFO_W-1:0]      fifo_rdata_s;

  assign valid_s  = {west_valid_i, south_valid_i, east_valid_i, north_valid_i};
  assign msg_s[0] = north_data_i;
  assign msg_s[1] = east_data_i;
  assign msg_s[2] = south_data_i;
  assign msg_s[3] = west_data_i;

`ifdef NX_COMBINER_RR_EN
  nx_direction_t last_q, last_d;
  nx_direction_t cand_s;

  // Round-robin search starting just after the last granted direction.
  always_comb begin
    grant_any_s = 1'b0;
    grant_dir_s = NX_DIRX_NORTH;
    cand_s      = last_q;
    for (int k = 0; k < NX_NUM_DIRS; k++) begin
      cand_s = nx_dir_next(cand_s);
      if (!grant_any_s && valid_s[cand_s]) begin
        grant_any_s = 1'b1;
        grant_dir_s = cand_s;
      end else begin
        grant_dir_s = grant_dir_s;
      end
    end
  end

  // Pointer moves only on an actual transfer.
  always_comb begin
    last_d = last_q;
    if (push_s) begin
      last_d = grant_dir_s;
    end else begin
      last_d = last_q;
    end
  end

  // Last-grant pointer; reset points at WEST so NORTH is searched first.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_q <= NX_DIRX_WEST;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority NORTH > EAST > SOUTH > WEST.
  always_comb begin
    grant_any_s = 1'b1;
    grant_dir_s = NX_DIRX_NORTH;
    if (valid_s[0]) begin
      grant_dir_s = NX_DIRX_NORTH;
    end else if (valid_s[1]) begin
      grant_dir_s = NX_DIRX_EAST;
    end else if (valid_s[2]) begin
      grant_dir_s = NX_DIRX_SOUTH;
    end else if (valid_s[3]) begin
      grant_dir_s = NX_DIRX_WEST;
    end else begin
      grant_any_s = 1'b0;
    end
  end
`endif

  // A transfer happens whenever a direction is granted and there is room;
  // reset forces all readies low.
  assign push_s       = rst_i && grant_any_s && !fifo_full_s;
  assign pop_s        = !fifo_empty_s && comb_ready_i;
  assign fifo_wdata_s = {msg_s[grant_dir_s], grant_dir_s};

  // One-hot inbound ready for the granted direction.
  always_comb begin
    ready_s = 4'b0000;
    if (push_s) begin
      ready_s[grant_dir_s] = 1'b1;
    end else begin
      ready_s = 4'b0000;
    end
  end

  assign north_ready_o = ready_s[0];
  assign east_ready_o  = ready_s[1];
  assign south_ready_o = ready_s[2];
  assign west_ready_o  = ready_s[3];

  nx_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_s),
    .wdata_i (fifo_wdata_s),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign comb_valid_o = !fifo_empty_s;
  assign comb_data_o  = fifo_rdata_s[FIFO_W-1:$bits(nx_direction_t)];
  assign comb_dir_o   = nx_direction_t'(fifo_rdata_s[$bits(nx_direction_t)-1:0]);
  assign idle_o       = fifo_empty_s && !(|valid_s);

endmodule

// File: doc/nx_stream_combiner.md
NX_STREAM_COMBINER -- requirements
Module: nx_stream_combiner

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning egress FIFO depth in messages (minimum 2).
REQ-002 SHALL have port clk_i  input  1  the single clock.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port idle_o  output  1  combiner idle flag.
REQ-005 SHALL have ports north_data_i / east_data_i / south_data_i / west_data_i, each input, $bits(nx_message_t): inbound message per direction.
REQ-006 SHALL have ports north_valid_i / east_valid_i / south_valid_i / west_valid_i, each input, 1 bit: inbound valid per direction.
REQ-007 SHALL have ports north_ready_o / east_ready_o / south_ready_o / west_ready_o, each output, 1 bit: inbound ready per direction.
REQ-008 SHALL have port comb_data_o  output  $bits(nx_message_t)  outbound message.
REQ-009 SHALL have port comb_dir_o  output  $bits(nx_direction_t)  direction the outbound message arrived from.
REQ-010 SHALL have port comb_valid_o  output  1  outbound valid.
REQ-011 SHALL have port comb_ready_i  input  1  outbound ready.

Function
REQ-012 SHALL grant at most one inbound direction per cycle; a transfer occurs when the granted valid and the matching ready are both high at a rising clock edge.
REQ-013 SHALL assert <dir>_ready_o only for the granted direction, and only when the egress FIFO is not full; ready is combinational from valid, grant state and FIFO full.
REQ-014 SHALL push {message, source direction} into the egress FIFO on each accepted transfer.
REQ-015 SHALL drive comb_valid_o = FIFO not empty, with comb_data_o/comb_dir_o taken from the FIFO head; pop on comb_valid_o && comb_ready_i.
REQ-016 SHALL have latency of exactly 1 cycle from accepted transfer to comb_valid_o when the FIFO was empty.
REQ-017 SHALL sustain 1 message/cycle when comb_ready_i is held high; a push and a pop in the same cycle while the FIFO is full SHALL be refused (ready low), with no combinational path from comb_ready_i to any inbound ready.
REQ-018 SHALL hold the grant pointer unchanged in cycles with no transfer; a valid that is not accepted SHALL NOT be dropped, and its data SHALL be sampled only on acceptance.
REQ-019 SHALL drive idle_o = FIFO empty && no inbound valid asserted.
REQ-020 SHALL treat the inbound direction ordering as NORTH, EAST, SOUTH, WEST (nx_direction_t encodings 0..3), wrapping WEST to NORTH.

Reset
REQ-021 SHALL, while rst_i is low, immediately empty the FIFO and set the last-grant pointer to WEST.
REQ-022 SHALL hold all ready outputs and comb_valid_o at 0 during reset, and idle_o at 1 unless an inbound valid is high.
REQ-023 SHALL discard FIFO contents when reset is asserted mid-operation; transfers resume on the first edge after rst_i deasserts.

Configuration
REQ-024 SHALL, with NX_COMBINER_RR_EN defined, use round-robin arbitration: the search starts at the direction after the last granted one, and the pointer updates to the granted direction on each transfer.
REQ-025 SHALL, without NX_COMBINER_RR_EN, use fixed priority NORTH > EAST > SOUTH > WEST; the pointer register is not implemented.

Structure
REQ-026 SHALL take nx_message_t, nx_direction_t and the NX_DIRX_* constants from the shared nx package; no new package types are required.
REQ-027 SHALL instantiate one nx_fifo (WIDTH = $bits(nx_message_t)+$bits(nx_direction_t), DEPTH = DEPTH) as its sole sub-module; the arbiter SHALL be implemented inline.

Verification
REQ-028 SHALL cover a single transfer: east_valid_i=1 with data 0x0A5 for one cycle, comb_ready_i=1 -> east_ready_o=1, next cycle comb_valid_o=1, comb_data_o=0x0A5, comb_dir_o=EAST.
REQ-029 SHALL cover round-robin (RR_EN): all four valids held high for 8 cycles -> grants N,E,S,W,N,E,S,W; without the macro -> 8 NORTH grants.
REQ-030 SHALL cover backpressure: comb_ready_i=0 with north streaming -> exactly 2 accepted, north_ready_o=0 thereafter; raising comb_ready_i -> in-order drain with no loss or duplication.
REQ-031 SHALL cover a stall hold: west_valid_i held while the FIFO is full -> data unchanged until accepted, output emitted exactly once.
REQ-032 SHALL cover reset: drive rst_i low asynchronously with 2 messages queued -> comb_valid_o drops before the next edge; after release the first grant goes to NORTH.
REQ-033 SHALL cover the idle flag: idle_o=1 only when the FIFO is empty and all valids are low.
